// File: rtl/dp_control_unit_if.sv
// Handshake and datapath-control bundle between dp_control_unit and its
// surroundings. The controller uses the slave view; whoever owns start/stall
// and the datapath flags uses the master view.
interface dp_control_unit_if;
  // handshake
  logic       start;
  logic       stall;
  logic       busy;
  logic       done;
  logic [3:0] iter_cnt;
  // datapath flags
  logic       iLe10;
  logic       aBTb;
  // datapath controls
  logic       RFSrcMuxSel;
  logic [2:0] readAddr1;
  logic [2:0] readAddr2;
  logic [2:0] writeAddr;
  logic       writeEn;
  logic       outBuf;
  logic [2:0] aluOP;

  modport slave (
    input  start, stall, iLe10, aBTb,
    output RFSrcMuxSel, readAddr1, readAddr2, writeAddr, writeEn, outBuf,
           aluOP, busy, done, iter_cnt
  );

  modport master (
    output start, stall, iLe10, aBTb,
    input  RFSrcMuxSel, readAddr1, readAddr2, writeAddr, writeEn, outBuf,
           aluOP, busy, done, iter_cnt
  );
endinterface

// File: rtl/dp_control_unit.sv
// Moore controller sequencing the register-file/ALU datapath to accumulate
// 1+2+...+10. Register map: R0 = 0 (hardwired), R1 = i, R2 = sum, R3 = 1.
// Controls are decoded from the state register; stall freezes the FSM and
// masks every side effect (RF write, output load, done pulse).
module dp_control_unit #(
  parameter int LIMIT_ITERS = 10
) (
  input  logic               clk,
  input  logic               reset,   // asynchronous, active low
  dp_control_unit_if.slave   bus
);

  // The iteration counter is 4 bits wide; refuse a limit it cannot hold.
  if (LIMIT_ITERS < 1 || LIMIT_ITERS > 15) begin : g_limit_check
    $error("LIMIT_ITERS does not fit the 4-bit iteration counter");
  end

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] R_ZERO  = 3'd0;
  localparam logic [2:0] R_I     = 3'd1;
  localparam logic [2:0] R_SUM   = 3'd2;
  localparam logic [2:0] R_ONE   = 3'd3;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_INIT_SUM = 4'd1,
    S_INIT_I   = 4'd2,
    S_INIT_ONE = 4'd3,
    S_CMP      = 4'd4,
    S_ADD      = 4'd5,
    S_INC      = 4'd6,
    S_OUT      = 4'd7,
    S_DONE     = 4'd8
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] iter_cnt_q, iter_cnt_d;

  logic       sel_s;
  logic [2:0] ra1_s, ra2_s, wa_s, op_s;
  logic       we_s, ob_s, busy_s, done_s;

  // aBTb is part of the datapath contract but this sequence never branches on it
  logic       unused_abtb_s;
  assign unused_abtb_s = bus.aBTb;

  // True for the nine encodings the FSM actually uses.
  function automatic logic state_is_legal(input state_e s);
    logic legal;
    case (s)
      S_IDLE, S_INIT_SUM, S_INIT_I, S_INIT_ONE, S_CMP,
      S_ADD, S_INC, S_OUT, S_DONE: legal = 1'b1;
      default:                     legal = 1'b0;
    endcase
    return legal;
  endfunction

  // State and iteration counter registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      iter_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      iter_cnt_q <= iter_cnt_d;
    end
  end

  // Next-state and counter update; a stall holds everything in place.
  always_comb begin
    state_d    = state_q;
    iter_cnt_d = iter_cnt_q;
    if (bus.stall && state_is_legal(state_q)) begin
      state_d    = state_q;
      iter_cnt_d = iter_cnt_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d    = S_INIT_SUM;
            iter_cnt_d = 4'd0;
          end else begin
            state_d    = S_IDLE;
          end
        end
        S_INIT_SUM: state_d = S_INIT_I;
        S_INIT_I:   state_d = S_INIT_ONE;
        S_INIT_ONE: state_d = S_CMP;
        S_CMP: begin
          if (bus.iLe10) begin
            state_d = S_ADD;
          end else begin
            state_d = S_DONE;
          end
        end
        S_ADD:      state_d = S_INC;
        S_INC:      state_d = S_OUT;
        S_OUT: begin
          state_d    = S_CMP;
          iter_cnt_d = iter_cnt_q + 4'd1;
        end
        S_DONE:     state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // Moore decode of datapath controls; stall masks the side-effect strobes.
  always_comb begin
    sel_s  = 1'b0;
    ra1_s  = R_ZERO;
    ra2_s  = R_ZERO;
    wa_s   = R_ZERO;
    op_s   = ALU_ADD;
    we_s   = 1'b0;
    ob_s   = 1'b0;
    busy_s = 1'b1;
    done_s = 1'b0;
    case (state_q)
      S_IDLE: busy_s = 1'b0;
      S_INIT_SUM: begin          // R2 <= R0 + R0
        wa_s = R_SUM;
        we_s = 1'b1;
      end
      S_INIT_I: begin            // R1 <= 1
        sel_s = 1'b1;
        wa_s  = R_I;
        we_s  = 1'b1;
      end
      S_INIT_ONE: begin          // R3 <= 1
        sel_s = 1'b1;
        wa_s  = R_ONE;
        we_s  = 1'b1;
      end
      S_CMP: ra1_s = R_I;        // iLe10 evaluates i
      S_ADD: begin               // R2 <= R2 + R1
        ra1_s = R_SUM;
        ra2_s = R_I;
        wa_s  = R_SUM;
        we_s  = 1'b1;
      end
      S_INC: begin               // R1 <= R1 + R3
        ra1_s = R_I;
        ra2_s = R_ONE;
        wa_s  = R_I;
        we_s  = 1'b1;
      end
      S_OUT: begin               // running sum to outPort
        ra1_s = R_SUM;
        ob_s  = 1'b1;
      end
      S_DONE: begin              // final sum reloaded, completion pulse
        ra1_s  = R_SUM;
        ob_s   = 1'b1;
        done_s = 1'b1;
      end
      default: busy_s = 1'b0;
    endcase
    if (bus.stall) begin
      we_s   = 1'b0;
      ob_s   = 1'b0;
      done_s = 1'b0;
    end else begin
      we_s   = we_s;
      ob_s   = ob_s;
      done_s = done_s;
    end
  end

  assign bus.RFSrcMuxSel = sel_s;
  assign bus.readAddr1   = ra1_s;
  assign bus.readAddr2   = ra2_s;
  assign bus.writeAddr   = wa_s;
  assign bus.aluOP       = op_s;
  assign bus.writeEn     = we_s;
  assign bus.outBuf      = ob_s;
  assign bus.busy        = busy_s;
  assign bus.done        = done_s;
  assign bus.iter_cnt    = iter_cnt_q;

endmodule

// File: tb/tb_dp_control_unit.sv
// Bench for dp_control_unit: a behavioural datapath (RF + ALU + outPort)
// closes the loop; a table of per-cycle vectors checks the decode, and
// randomized runs are checked against the cycle schedule of the sequence.
`timescale 1ns/1ps
module tb_dp_control_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dp_control_unit_if dpif();

  dp_control_unit #(.LIMIT_ITERS(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dpif)
  );

  // ---------------- datapath model ----------------
  logic [7:0] rf [0:7];
  logic [7:0] out_port;
  logic [7:0] rd1, rd2, alu_res, wdata;
  logic [7:0] outq [$];

  always_comb begin
    rd1 = (dpif.readAddr1 == 3'd0) ? 8'd0 : rf[dpif.readAddr1];
    rd2 = (dpif.readAddr2 == 3'd0) ? 8'd0 : rf[dpif.readAddr2];
    case (dpif.aluOP)
      3'b000:  alu_res = rd1 + rd2;
      3'b001:  alu_res = rd1 - rd2;
      3'b010:  alu_res = rd1 & rd2;
      3'b011:  alu_res = rd1 | rd2;
      3'b100:  alu_res = rd1 ^ rd2;
      3'b101:  alu_res = ~rd1;
      default: alu_res = 8'd0;
    endcase
    wdata = dpif.RFSrcMuxSel ? 8'd1 : alu_res;
  end

  assign dpif.iLe10 = (rd1 <= 8'd10);
  assign dpif.aBTb  = (rd1 <= rd2);

  always @(posedge clk) begin
    if (dpif.writeEn && dpif.writeAddr != 3'd0) rf[dpif.writeAddr] <= wdata;
    if (dpif.outBuf) begin
      out_port <= rd1;
      outq.push_back(rd1);
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) rf[i] <= 8'($urandom);
    out_port <= 8'd0;
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic       start;
    logic       stall;
    logic       sel;
    logic [2:0] ra1, ra2, wa, op;
    logic       we, ob, busy, done;
    logic [3:0] iter;
  } vec_t;

  vec_t tbl [$];

  task automatic add_vec(input logic st, input logic sl, input logic sel,
                         input logic [2:0] ra1, input logic [2:0] ra2,
                         input logic [2:0] wa, input logic [2:0] op,
                         input logic we, input logic ob, input logic busy,
                         input logic done, input logic [3:0] iter);
    vec_t v;
    v.start = st; v.stall = sl; v.sel = sel; v.ra1 = ra1; v.ra2 = ra2;
    v.wa = wa; v.op = op; v.we = we; v.ob = ob; v.busy = busy;
    v.done = done; v.iter = iter;
    tbl.push_back(v);
  endtask

  function automatic logic [20:0] pack_exp(input vec_t v);
    return {v.sel, v.ra1, v.ra2, v.wa, v.op, v.we, v.ob, v.busy, v.done, v.iter};
  endfunction

  function automatic logic [20:0] pack_dut();
    return {dpif.RFSrcMuxSel, dpif.readAddr1, dpif.readAddr2, dpif.writeAddr,
            dpif.aluOP, dpif.writeEn, dpif.outBuf, dpif.busy, dpif.done,
            dpif.iter_cnt};
  endfunction

  // ---------------- schedule reference ----------------
  // Busy cycle k (0-based, stalls not counted): 0..2 init, then iteration j
  // occupies CMP/ADD/INC/OUT at 3+4j..6+4j, final CMP at 43, DONE at 44.
  function automatic int exp_we(input int k);
    if (k <= 2) return 1;
    if (k <= 42 && (((k - 3) % 4) == 1 || ((k - 3) % 4) == 2)) return 1;
    return 0;
  endfunction

  function automatic int exp_ob(input int k);
    if (k == 44) return 1;
    if (k >= 3 && k <= 42 && ((k - 3) % 4) == 3) return 1;
    return 0;
  endfunction

  function automatic int exp_iter(input int k);
    int n;
    if (k < 7) return 0;
    n = (k - 7) / 4 + 1;
    return (n > 10) ? 10 : n;
  endfunction

  // One full run from IDLE with randomized/forced stalls, checked per cycle.
  task automatic random_run(input int stall_pct, input int stall_at,
                            input int stall_len, input bit hold_start,
                            input bit rand_start, output int busy_cycles);
    int p, stall_left, dones, guard, stalls_busy, s;
    logic st;
    logic [7:0] exp_q [$];
    s = 0;
    for (int i = 1; i <= 10; i++) begin
      s += i;
      exp_q.push_back(8'(s));
    end
    exp_q.push_back(8'(s));
    outq.delete();
    p = -1; busy_cycles = 0; stall_left = stall_len; dones = 0;
    guard = 0; stalls_busy = 0;
    while (p < 45 && guard < 600) begin
      if (p == stall_at && stall_left > 0) begin
        st = 1'b1;
        stall_left--;
      end else begin
        st = ($urandom_range(99) < stall_pct);
      end
      dpif.stall = st;
      if (p < 0)           dpif.start = 1'b1;
      else if (hold_start) dpif.start = 1'b1;
      else if (rand_start) dpif.start = 1'($urandom_range(1));
      else                 dpif.start = 1'b0;
      #1;
      if (p < 0) begin
        chk("idle_busy", int'(dpif.busy), 0);
      end else begin
        busy_cycles++;
        if (st) stalls_busy++;
        chk($sformatf("busy k=%0d", p), int'(dpif.busy), 1);
        chk($sformatf("done k=%0d", p), int'(dpif.done), (!st && p == 44) ? 1 : 0);
        chk($sformatf("we k=%0d st=%0d", p, st), int'(dpif.writeEn), st ? 0 : exp_we(p));
        chk($sformatf("ob k=%0d st=%0d", p, st), int'(dpif.outBuf), st ? 0 : exp_ob(p));
        chk($sformatf("iter k=%0d", p), int'(dpif.iter_cnt), exp_iter(p));
        if (dpif.done) dones++;
      end
      tick();
      guard++;
      if (p < 0) begin
        if (!st) p = 0;
      end else if (!st) begin
        p++;
      end
    end
    chk("run_completes", p, 45);
    chk("busy_cycles", busy_cycles, 45 + stalls_busy);
    chk("done_pulses", dones, 1);
    chk("outq_len", outq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < outq.size(); i++)
      chk($sformatf("outPort[%0d]", i), int'(outq[i]), int'(exp_q[i]));
    chk("final_outPort", int'(out_port), 55);
    chk("final_iter", int'(dpif.iter_cnt), 10);
    chk("final_busy", int'(dpif.busy), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int cyc, bc;
    dpif.start = 1'b0;
    dpif.stall = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_vector", int'(pack_dut()), 0);
    chk("rst_busy", int'(dpif.busy), 0);
    chk("rst_iter", int'(dpif.iter_cnt), 0);
    reset = 1'b1;
    tick();

    //       st  sl  sel ra1   ra2   wa    op    we  ob  bsy dn  iter
    add_vec(1'b1,1'b1,1'b0,3'd0,3'd0,3'd0,3'd0,1'b0,1'b0,1'b0,1'b0,4'd0); // IDLE, stalled start
    add_vec(1'b1,1'b0,1'b0,3'd0,3'd0,3'd0,3'd0,1'b0,1'b0,1'b0,1'b0,4'd0); // IDLE, start taken
    add_vec(1'b0,1'b0,1'b0,3'd0,3'd0,3'd2,3'd0,1'b1,1'b0,1'b1,1'b0,4'd0); // INIT_SUM
    add_vec(1'b0,1'b0,1'b1,3'd0,3'd0,3'd1,3'd0,1'b1,1'b0,1'b1,1'b0,4'd0); // INIT_I
    add_vec(1'b0,1'b0,1'b1,3'd0,3'd0,3'd3,3'd0,1'b1,1'b0,1'b1,1'b0,4'd0); // INIT_ONE
    add_vec(1'b0,1'b0,1'b0,3'd1,3'd0,3'd0,3'd0,1'b0,1'b0,1'b1,1'b0,4'd0); // CMP
    add_vec(1'b0,1'b1,1'b0,3'd2,3'd1,3'd2,3'd0,1'b0,1'b0,1'b1,1'b0,4'd0); // ADD stalled
    add_vec(1'b0,1'b0,1'b0,3'd2,3'd1,3'd2,3'd0,1'b1,1'b0,1'b1,1'b0,4'd0); // ADD
    add_vec(1'b1,1'b0,1'b0,3'd1,3'd3,3'd1,3'd0,1'b1,1'b0,1'b1,1'b0,4'd0); // INC, start ignored
    add_vec(1'b0,1'b1,1'b0,3'd2,3'd0,3'd0,3'd0,1'b0,1'b0,1'b1,1'b0,4'd0); // OUT stalled
    add_vec(1'b0,1'b0,1'b0,3'd2,3'd0,3'd0,3'd0,1'b0,1'b1,1'b1,1'b0,4'd0); // OUT
    add_vec(1'b0,1'b0,1'b0,3'd1,3'd0,3'd0,3'd0,1'b0,1'b0,1'b1,1'b0,4'd1); // CMP
    add_vec(1'b0,1'b0,1'b0,3'd2,3'd1,3'd2,3'd0,1'b1,1'b0,1'b1,1'b0,4'd1); // ADD

    for (int i = 0; i < tbl.size(); i++) begin
      dpif.start = tbl[i].start;
      dpif.stall = tbl[i].stall;
      #1;
      chk($sformatf("vec[%0d]", i), int'(pack_dut()), int'(pack_exp(tbl[i])));
      tick();
    end
    chk("tbl_outPort_first", int'(out_port), 1);

    // Finish the table run: two stalled cycles push done to cycle 47.
    dpif.start = 1'b0;
    dpif.stall = 1'b0;
    cyc = 12;
    for (int g = 0; g < 200; g++) begin
      #1;
      if (dpif.done) break;
      tick();
      cyc++;
    end
    chk("tbl_done_cycle", cyc, 47);
    chk("tbl_done_iter", int'(dpif.iter_cnt), 10);
    tick();
    chk("tbl_final_outPort", int'(out_port), 55);
    chk("tbl_idle_busy", int'(dpif.busy), 0);

    // Clean run: exactly 45 busy cycles.
    random_run(0, -1, 0, 1'b0, 1'b0, bc);
    chk("plain_latency", bc, 45);
    // Five stalled cycles in ADD of iteration 4: 50 busy cycles.
    random_run(0, 16, 5, 1'b0, 1'b0, bc);
    chk("stall5_latency", bc, 50);
    // start toggling randomly while busy must not restart the run.
    random_run(0, -1, 0, 1'b0, 1'b1, bc);
    chk("restart_ignored_latency", bc, 45);
    // Back-to-back runs with start held high, random stalls.
    random_run(15, -1, 0, 1'b1, 1'b0, bc);
    random_run(15, -1, 0, 1'b1, 1'b0, bc);

    // Reset during iteration 6 clears state and counter asynchronously.
    dpif.stall = 1'b0;
    dpif.start = 1'b1;
    tick();
    dpif.start = 1'b0;
    repeat (25) tick();
    #1;
    chk("pre_reset_iter", int'(dpif.iter_cnt), 5);
    chk("pre_reset_busy", int'(dpif.busy), 1);
    reset = 1'b0;
    #1;
    chk("async_rst_busy", int'(dpif.busy), 0);
    chk("async_rst_done", int'(dpif.done), 0);
    chk("async_rst_iter", int'(dpif.iter_cnt), 0);
    chk("async_rst_vector", int'(pack_dut()), 0);
    tick();
    reset = 1'b1;
    tick();

    // Fresh runs after the reset, with random stalls and start noise.
    for (int r = 0; r < 3; r++) random_run(25, -1, 0, 1'b0, 1'b1, bc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
